// File: rtl/sic_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sic_mem_arbiter_pkg
// Shared types and helpers for the SIC memory arbiter.
//   arb_state_t : arbiter ownership state (IDLE / OWNED)
//   id_older    : wrap-aware issue_id age compare. The issue/ROB logic uses it too.
// -----------------------------------------------------------------------------
package sic_mem_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int WORD_WIDTH   = 32;   // data word width
    localparam int WADDR_WIDTH  = 30;   // word address width (byte addr[31:2])
    localparam int MAX_ID_WIDTH = 32;   // widest issue_id id_older() accepts

    // Returns 1 when a was issued before b. Callers zero-extend their
    // ID_WIDTH-bit ids to MAX_ID_WIDTH. The low ID_WIDTH bits of the 32-bit
    // difference equal (a-b) mod 2^ID_WIDTH, so the sign bit of the narrow
    // difference can be taken from bit (width-1). The result is valid while
    // the live ids span less than half the id space.
    function automatic logic id_older(
        input logic [MAX_ID_WIDTH-1:0] a,
        input logic [MAX_ID_WIDTH-1:0] b,
        input int unsigned             width
    );
        logic [MAX_ID_WIDTH-1:0] diff;
        diff = (a - b) >> (width - 1);
        return diff[0];
    endfunction

endpackage

// File: rtl/sic_mem_arbiter_picker.sv
// -----------------------------------------------------------------------------
// sic_age_picker
// Combinational oldest-eligible selector.
// Ports:
//   valid  in  NUM_SIC            eligibility mask
//   ids    in  NUM_SIC*ID_WIDTH   packed issue_ids (SIC i at [i*ID_WIDTH +: ID_WIDTH])
//   onehot out NUM_SIC            one-hot winner (zero when nothing is valid)
//   index  out IDX_WIDTH          winner index (zero when nothing is valid)
//   any    out 1                  some requester is valid
// -----------------------------------------------------------------------------
module sic_age_picker
    import sic_mem_arbiter_pkg::*;
#(
    parameter  int NUM_SIC   = 4,
    parameter  int ID_WIDTH  = 8,
    localparam int IDX_WIDTH = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1
) (
    input  logic [NUM_SIC-1:0]          valid,
    input  logic [NUM_SIC*ID_WIDTH-1:0] ids,
    output logic [NUM_SIC-1:0]          onehot,
    output logic [IDX_WIDTH-1:0]        index,
    output logic                        any
);

    logic [ID_WIDTH-1:0] id_arr [NUM_SIC];

    generate
        for (genvar gi = 0; gi < NUM_SIC; gi++) begin : g_unpack
            assign id_arr[gi] = ids[gi*ID_WIDTH +: ID_WIDTH];
        end
    endgenerate

    // Linear scan from index 0. A later candidate replaces the current best
    // only when it is strictly older, so equal ids go to the lowest index.
    always_comb begin
        index = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_SIC; i++) begin
            if (valid[i] && (!any ||
                id_older(MAX_ID_WIDTH'(id_arr[i]), MAX_ID_WIDTH'(id_arr[index]), ID_WIDTH))) begin
                index = IDX_WIDTH'(i);
                any   = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SIC; gi++) begin : g_onehot
            assign onehot[gi] = any && (index == IDX_WIDTH'(gi));
        end
    endgenerate

endmodule

// File: rtl/sic_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sic_mem_arbiter
// This is the responder end of the SIC memory lock/request protocol. It picks
// one SIC to own the data RAM, oldest issue_id first, and performs the owner's
// access in the grant cycle.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req           per-SIC lock request (level)
//   req_issue_id  packed issue_ids, NUM_SIC x ID_WIDTH
//   release_lock  owner releases the lock in its grant cycle
//   addr          packed word addresses, NUM_SIC x 30
//   wdata         packed store data, NUM_SIC x 32
//   wen           store enable (only the owner's is honoured)
//   grant         one-hot lock grant
//   rdata         RAM word at the owner's address (index 0 when idle)
// Optional build macro SIC_MEM_ARB_STATS_EN adds these outputs:
//   grant_count   releases seen (wraps at 2^32)
//   cancel_count  owner req drops seen (wraps at 2^32)
// -----------------------------------------------------------------------------
module sic_mem_arbiter
    import sic_mem_arbiter_pkg::*;
#(
    parameter int NUM_SIC   = 4,
    parameter int ID_WIDTH  = 8,
    parameter int MEM_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SIC-1:0]             req,
    input  logic [NUM_SIC*ID_WIDTH-1:0]    req_issue_id,
    input  logic [NUM_SIC-1:0]             release_lock,
    input  logic [NUM_SIC*WADDR_WIDTH-1:0] addr,
    input  logic [NUM_SIC*WORD_WIDTH-1:0]  wdata,
    input  logic [NUM_SIC-1:0]             wen,
    output logic [NUM_SIC-1:0]             grant,
    output logic [WORD_WIDTH-1:0]          rdata
`ifdef SIC_MEM_ARB_STATS_EN
    ,
    output logic [31:0]                    grant_count,
    output logic [31:0]                    cancel_count
`endif
);

    localparam int IDX_WIDTH = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1;
    localparam int MEM_AW    = $clog2(MEM_WORDS);

    arb_state_t             state_reg, state_next;
    logic [IDX_WIDTH-1:0]   owner_reg, owner_next;

    logic [WADDR_WIDTH-1:0] addr_arr  [NUM_SIC];
    logic [WORD_WIDTH-1:0]  wdata_arr [NUM_SIC];
    logic [NUM_SIC-1:0]     owner_mask;
    logic [NUM_SIC-1:0]     eligible;
    logic [NUM_SIC-1:0]     pick_onehot;
    logic [IDX_WIDTH-1:0]   pick_index;
    logic                   pick_any;

    logic                   owner_req, owner_rel, owner_wen;
    logic [WADDR_WIDTH-1:0] owner_addr;
    logic [WORD_WIDTH-1:0]  owner_wdata;
    logic                   owner_release, owner_cancel;
    logic                   write_en;
    logic [MEM_AW-1:0]      ram_index;

    logic [WORD_WIDTH-1:0]  mem [MEM_WORDS];

    generate
        for (genvar gi = 0; gi < NUM_SIC; gi++) begin : g_sic
            assign addr_arr[gi]   = addr[gi*WADDR_WIDTH +: WADDR_WIDTH];
            assign wdata_arr[gi]  = wdata[gi*WORD_WIDTH +: WORD_WIDTH];
            assign owner_mask[gi] = (state_reg == OWNED) && (owner_reg == IDX_WIDTH'(gi));
        end
    endgenerate

    assign grant = owner_mask;

    // The current owner is never a candidate for its own succession. This is
    // what gives one access per cycle when the queue behind it is non-empty.
    assign eligible = req & ~owner_mask;

    sic_age_picker #(
        .NUM_SIC  (NUM_SIC),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .valid  (eligible),
        .ids    (req_issue_id),
        .onehot (pick_onehot),
        .index  (pick_index),
        .any    (pick_any)
    );

    assign owner_req   = req[owner_reg];
    assign owner_rel   = release_lock[owner_reg];
    assign owner_wen   = wen[owner_reg];
    assign owner_addr  = addr_arr[owner_reg];
    assign owner_wdata = wdata_arr[owner_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        owner_release = 1'b0;
        owner_cancel  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next = OWNED;
                    owner_next = pick_index;
                end
            end
            OWNED: begin
                // A release takes precedence over a simultaneous req drop.
                owner_release = owner_rel;
                owner_cancel  = !owner_rel && !owner_req;
                if (owner_release || owner_cancel) begin
                    if (pick_any) begin
                        owner_next = pick_index;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // state_reg clears asynchronously, so an edge taken while rst_n is low
    // can never commit a write.
    assign write_en  = (state_reg == OWNED) && owner_req && owner_wen;
    assign ram_index = (state_reg == OWNED) ? owner_addr[MEM_AW-1:0] : '0;

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[ram_index] <= owner_wdata;
        end
    end

    // Asynchronous read: the write cycle shows the word before the write.
    assign rdata = mem[ram_index];

    // The upper address bits wrap by design. pick_onehot is not needed here
    // because the index drives the owner register.
    logic unused_ok;
    assign unused_ok = ^{owner_addr, pick_onehot};

`ifdef SIC_MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count  <= '0;
            cancel_count <= '0;
        end else begin
            if (owner_release) grant_count  <= grant_count + 32'd1;
            if (owner_cancel)  cancel_count <= cancel_count + 32'd1;
        end
    end

    grant_onehot0_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
`endif

endmodule

// File: tb/tb_sic_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sic_mem_arbiter
// Directed bench for sic_mem_arbiter. A behavioural ownership/RAM model
// checks grant and rdata on every falling edge. Hand-computed literals pin
// the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_sic_mem_arbiter;

    localparam int N   = 4;
    localparam int IDW = 8;
    localparam int MW  = 1024;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       req;
    logic [N*IDW-1:0]   req_issue_id;
    logic [N-1:0]       release_lock;
    logic [N*30-1:0]    addr;
    logic [N*32-1:0]    wdata;
    logic [N-1:0]       wen;
    logic [N-1:0]       grant;
    logic [31:0]        rdata;
`ifdef SIC_MEM_ARB_STATS_EN
    logic [31:0]        grant_count;
    logic [31:0]        cancel_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sic_mem_arbiter #(
        .NUM_SIC   (N),
        .ID_WIDTH  (IDW),
        .MEM_WORDS (MW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_issue_id (req_issue_id),
        .release_lock (release_lock),
        .addr         (addr),
        .wdata        (wdata),
        .wen          (wen),
        .grant        (grant),
        .rdata        (rdata)
`ifdef SIC_MEM_ARB_STATS_EN
        ,
        .grant_count  (grant_count),
        .cancel_count (cancel_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_sic(input int i, input logic r, input logic [7:0] id,
                           input logic [29:0] a, input logic [31:0] wd,
                           input logic we, input logic rl);
        req[i]                   = r;
        req_issue_id[i*IDW +: IDW] = id;
        addr[i*30 +: 30]         = a;
        wdata[i*32 +: 32]        = wd;
        wen[i]                   = we;
        release_lock[i]          = rl;
    endtask

    task automatic drop(input int i);
        req[i]          = 1'b0;
        wen[i]          = 1'b0;
        release_lock[i] = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // A single store that is granted next cycle and released in its grant cycle.
    task automatic write_txn(input int i, input logic [7:0] id, input logic [29:0] a, input logic [31:0] d);
        set_sic(i, 1'b1, id, a, d, 1'b1, 1'b1);
        tick;
        tick;
        drop(i);
    endtask

    // ---------------- behavioural model ----------------
    int          m_owner = -1;
    logic [31:0] m_mem   [MW];
    bit          m_known [MW];

    // Ages are ranked by signed distance from one live id. With all live ids
    // inside half the id space, the most negative distance is the oldest.
    function automatic int oldest(input int excl);
        int               best = -1;
        logic [7:0]       ref_id = '0;
        logic signed [7:0] best_key = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && i != excl && best < 0) begin
                ref_id = req_issue_id[i*IDW +: IDW];
                best   = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req[i] && i != excl) begin
                logic [7:0]        d;
                logic signed [7:0] key;
                d   = req_issue_id[i*IDW +: IDW] - ref_id;
                key = $signed(d);
                if (key < best_key) begin
                    best     = i;
                    best_key = key;
                end
            end
        end
        return best;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner = -1;
        end else if (m_owner >= 0) begin
            int         o;
            logic [9:0] idx;
            o   = m_owner;
            idx = addr[o*30 +: 10];
            if (req[o] && wen[o]) begin
                m_mem[idx]   = wdata[o*32 +: 32];
                m_known[idx] = 1'b1;
            end
            if (release_lock[o] || !req[o]) m_owner = oldest(o);
        end else begin
            m_owner = oldest(-1);
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_grant;
        logic [9:0]   idx;
        exp_grant = (rst_n && m_owner >= 0) ? N'(1 << m_owner) : '0;
        check("grant_model", 32'(grant), 32'(exp_grant));
        if (rst_n && m_owner >= 0) begin
            idx = addr[m_owner*30 +: 10];
            if (m_known[idx]) check("rdata_model", rdata, m_mem[idx]);
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        req = '0; req_issue_id = '0; release_lock = '0;
        addr = '0; wdata = '0; wen = '0;

        tick;
        tick;
        check("reset_grant", 32'(grant), 32'h0);
`ifdef SIC_MEM_ARB_STATS_EN
        check("reset_grant_count", grant_count, 32'h0);
`endif
        #2 rst_n = 1'b1;
        tick;
        check("idle_after_reset", 32'(grant), 32'h0);

        // Single requester store, then a read of the same word by SIC1.
        set_sic(0, 1'b1, 8'd5, 30'h10, 32'hDEADBEEF, 1'b1, 1'b1);
        tick;
        check("t1_grant_sic0", 32'(grant), 32'h1);
        tick;
        drop(0);
        set_sic(1, 1'b1, 8'd6, 30'h10, 32'h0, 1'b0, 1'b1);
        tick;
        check("t1_grant_sic1", 32'(grant), 32'h2);
        check("t1_rdata", rdata, 32'hDEADBEEF);
        tick;
        drop(1);
        check("t1_idle", 32'(grant), 32'h0);

        // Age order: id 3 before id 7, back to back.
        set_sic(1, 1'b1, 8'd7, 30'h10, 32'h0, 1'b0, 1'b1);
        set_sic(2, 1'b1, 8'd3, 30'h10, 32'h0, 1'b0, 1'b1);
        tick;
        check("t2_first_sic2", 32'(grant), 32'h4);
        tick;
        check("t2_next_sic1", 32'(grant), 32'h2);
        drop(2);
        tick;
        check("t2_idle", 32'(grant), 32'h0);
        drop(1);

        // Wrap-around: 0xFE is older than 0x01.
        set_sic(0, 1'b1, 8'hFE, 30'h10, 32'h0, 1'b0, 1'b1);
        set_sic(3, 1'b1, 8'h01, 30'h10, 32'h0, 1'b0, 1'b1);
        tick;
        check("t3_wrap_sic0", 32'(grant), 32'h1);
        tick;
        check("t3_then_sic3", 32'(grant), 32'h8);
        drop(0);
        tick;
        check("t3_idle", 32'(grant), 32'h0);
        drop(3);

        // Abort: the owner drops req with wen high, so no write is performed.
        write_txn(0, 8'd20, 30'h20, 32'h11111111);
        set_sic(2, 1'b1, 8'd10, 30'h20, 32'hBAD0BAD0, 1'b1, 1'b0);
        set_sic(3, 1'b1, 8'd12, 30'h20, 32'h0, 1'b0, 1'b1);
        tick;
        check("t4_owner_sic2", 32'(grant), 32'h4);
        req[2] = 1'b0;
        tick;
        check("t4_rearb_sic3", 32'(grant), 32'h8);
        check("t4_no_write", rdata, 32'h11111111);
`ifdef SIC_MEM_ARB_STATS_EN
        check("t4_cancel_count", cancel_count, 32'h1);
`endif
        drop(2);
        tick;
        drop(3);
        check("t4_idle", 32'(grant), 32'h0);
`ifdef SIC_MEM_ARB_STATS_EN
        check("t4_grant_count", grant_count, 32'h8);
`endif

        // Tie goes to SIC0, which then holds for three cycles and writes each one.
        set_sic(0, 1'b1, 8'd9, 30'h30, 32'hA5A50001, 1'b1, 1'b0);
        set_sic(1, 1'b1, 8'd9, 30'h30, 32'h0, 1'b0, 1'b1);
        tick;
        check("t5_tie_sic0", 32'(grant), 32'h1);
        tick;
        check("t5_hold1", 32'(grant), 32'h1);
        check("t5_hold_write1", rdata, 32'hA5A50001);
        wdata[31:0] = 32'hA5A50002;
        tick;
        check("t5_hold2", 32'(grant), 32'h1);
        check("t5_hold_write2", rdata, 32'hA5A50002);
        wdata[31:0] = 32'hA5A50003;
        release_lock[0] = 1'b1;
        tick;
        check("t5_sic1_after_release", 32'(grant), 32'h2);
        check("t5_release_write", rdata, 32'hA5A50003);
        drop(0);
        tick;
        drop(1);
        check("t5_idle", 32'(grant), 32'h0);

        // Reset while owned: the grant drops at once and the pending write is lost.
        write_txn(0, 8'd30, 30'h40, 32'h12345678);
        set_sic(0, 1'b1, 8'd31, 30'h40, 32'h77777777, 1'b1, 1'b1);
        tick;
        check("t6_owned", 32'(grant), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_drop", 32'(grant), 32'h0);
`ifdef SIC_MEM_ARB_STATS_EN
        check("t6_stats_cleared", cancel_count, 32'h0);
`endif
        drop(0);
        tick;
        tick;
        #2 rst_n = 1'b1;
        tick;
        check("t6_idle_after", 32'(grant), 32'h0);
        set_sic(1, 1'b1, 8'd32, 30'h40, 32'h0, 1'b0, 1'b1);
        tick;
        check("t6_read_grant", 32'(grant), 32'h2);
        check("t6_no_write", rdata, 32'h12345678);
        tick;
        drop(1);
        check("t6_final_idle", 32'(grant), 32'h0);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sic_mem_arbiter.md
Name: sic_mem_arbiter

Overview:
- Responder end of the SIC memory lock/request protocol: arbitrates data-memory ownership among NUM_SIC exec-mem SICs and owns the data memory.
- Each SIC holds req with its issue_id until grant. The access completes in the grant cycle: write commits at the clock edge, read data is returned combinationally, and the SIC asserts release_lock in that same cycle.
- Oldest issue_id wins, using wrap-aware comparison. Sits between the SIC array and the data RAM.

Parameters:
- NUM_SIC, 4, number of requesting SICs (≥1)
- ID_WIDTH, 8, issue_id width
- MEM_WORDS, 1024, data RAM depth in 32-bit words (power of two)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_SIC  per-SIC memory lock request (level, held until granted or abandoned)
- req_issue_id  in  NUM_SIC×ID_WIDTH  issue_id of each requester
- release_lock  in  NUM_SIC  owner releases lock (same cycle as its grant)
- addr  in  NUM_SIC×30  word address (byte addr[31:2])
- wdata  in  NUM_SIC×32  store data
- wen  in  NUM_SIC  store enable, valid only while granted
- grant  out  NUM_SIC  one-hot lock grant
- rdata  out  32  RAM read data at owner's addr (broadcast)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, owner invalid, grant=0. rdata reads RAM at index 0 (combinational). RAM contents are not reset.
- States:
  - IDLE: no owner.
  - OWNED: owner index registered; grant[owner]=1 combinationally while in OWNED.
- Selection (combinational, over eligible requesters):
  - Winner is the eligible index whose issue_id is oldest.
  - a older than b ⇔ MSB of (a−b) mod 2^ID_WIDTH is 1. This is wrap-aware; live ids span < 2^(ID_WIDTH−1).
  - Equal ids: the lowest index wins.
- IDLE → OWNED: when any req is high, register the winner at the clock edge. Grant appears the next cycle, so grant latency is 1 cycle from req.
- OWNED, owner's release_lock=1:
  - Access completes this cycle.
  - Next state re-arbitrates among req with the owner excluded. It goes OWNED(new winner) if any remain, else IDLE.
  - Back-to-back throughput is one access per cycle.
- OWNED, owner's req=0 (abort/mispredict drop): cancel. No write occurs; re-arbitrate as above, with the owner excluded.
- OWNED, owner's req=1 and release_lock=0: stay OWNED. Grant is held, and a write is performed each cycle that wen=1.
- RAM:
  - Index = addr[owner][log2(MEM_WORDS)−1:0]; upper bits are ignored (wrap).
  - Write is synchronous: occurs when state=OWNED && req[owner] && wen[owner].
  - rdata = RAM[index] asynchronously, showing pre-write data in the write cycle.
- Non-owners: grant=0; their wen/addr are ignored.
- Reset mid-OWNED: grant drops immediately (async). A pending write in that cycle is not performed.

Optional Feature:
- Macro SIC_MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_count[31:0] (incremented on each release) and cancel_count[31:0] (incremented on each owner req-drop).
  - Both reset to 0 and wrap at 2^32.
  - Adds a simulation-only assertion that grant is one-hot-or-zero.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: arb_state_t enum (IDLE, OWNED) and the issue_id age-compare function id_older(a,b) (reused by the issue/ROB logic).
- One sub-module, sic_age_picker: combinational oldest-eligible selector (inputs valid mask + ids, outputs one-hot + index + any).

Test Plan:
- Single requester: SIC0 req, id=5, wen=1, addr=0x10, wdata=0xDEADBEEF.
  - Expect grant[0] one cycle after req; RAM[0x10]=0xDEADBEEF.
  - Then a read of addr 0x10 by SIC1 returns rdata=0xDEADBEEF in its grant cycle.
- Age order: SIC1 id=7 and SIC2 id=3 request together, both releasing on grant.
  - Expect grant[2] first, then grant[1] in the immediately following cycle (back-to-back), then IDLE.
- Wrap-around: ID_WIDTH=8, SIC0 id=0xFE, SIC3 id=0x01 → SIC0 granted first.
- Abort: SIC2 is owner and drops req with wen=1 and no release → no RAM write, and re-arbitrate to the next waiting requester. Under SIC_MEM_ARB_STATS_EN, cancel_count=1.
- Tie and hold: SIC0 and SIC1 both id=9 → SIC0 wins. SIC0 holds req with no release for 3 cycles → grant[0] stays 1 and SIC1 is not granted until the release.
- Reset mid-grant: assert rst_n=0 while OWNED with wen=1 → grant=0 immediately and no RAM write; after reset release, IDLE.
